vga_pixel_stream_buffer: RTL and testbench
==========================================

# vga_pixel_stream_buffer

Single-clock pixel buffer directly upstream of the VGA timing generator. It accepts an Avalon-ST RGB pixel stream, buffers it in a small FIFO and aligns each packet to the display frame using the timing generator's `end_of_frame` pulse. It presents one pixel per `read_enable` cycle and blanks/resynchronises on underflow or malformed packets.

## Interface
- `CW`, 9: colour channel MSB index; each channel is CW+1 bits.
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `FIFO_DEPTH`, 16: buffer entries; must be a power of 2.
- `AW`, 4: log2(FIFO_DEPTH).
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-low reset.
- `stream_data`  in  3*(CW+1)  pixel, {R,G,B}, R in the MSBs.
- `stream_startofpacket`  in  1  first pixel of a frame.
- `stream_endofpacket`  in  1  last pixel of a frame.
- `stream_valid`  in  1  source has a pixel.
- `stream_ready`  out  1  buffer accepts a pixel this cycle.
- `read_enable`  in  1  timing generator consumes a pixel this cycle.
- `end_of_frame`  in  1  one-cycle pulse from the timing generator, 2 cycles before line 0 / pixel 0.
- `red_to_vga_display`, `green_to_vga_display`, `blue_to_vga_display`  out  CW+1 each  pixel to the timing generator.
- `underflow`  out  1  one-cycle pulse when a pixel is consumed from an empty FIFO.
- `frame_error`  out  1  one-cycle pulse when a packet has a bad length or SOP/EOP placement.

## Operation
- FIFO entry = {sop, eop, data}. Push when `stream_valid & stream_ready`. `stream_ready = (count != FIFO_DEPTH)`. Count tracks simultaneous push and pop; it never exceeds FIFO_DEPTH and never goes below 0.
- Pixel counter, 19 bits: counts pops in RUN, 0 .. H_ACTIVE*V_ACTIVE-1. LAST = H_ACTIVE*V_ACTIVE-1.
- States:
  - DROP: while the FIFO is non-empty and the head sop=0, pop one entry per cycle and discard it. When the head sop=1, go to ARM.
  - ARM: hold the head. On `end_of_frame`, go to RUN and clear the pixel counter.
  - RUN, on `read_enable`:
    - FIFO empty: pulse `underflow`, output black, go to DROP.
    - Head sop=1 and counter != 0: early SOP. Pulse `frame_error`, do not pop, go to ARM.
    - Otherwise pop and increment the counter, then:
      - counter == LAST and eop=1: normal end, go to DROP.
      - counter == LAST and eop=0: pulse `frame_error`, go to DROP; the packet remainder is discarded there.
      - counter < LAST and eop=1: pulse `frame_error`, go to DROP.
  - In RUN without `read_enable`: hold.
- Colour outputs are combinational from the FIFO head when state=RUN, `read_enable`=1 and the FIFO is non-empty. Otherwise all zero.
- `end_of_frame` outside ARM is ignored.

## Timing
- Reset (asynchronous, `reset`=0): FIFO empty, count=0, state=DROP, counter=0, `underflow`=0, `frame_error`=0, colours=0, `stream_ready`=1.
- Reset mid-frame discards all buffered data. The first frame after reset waits for an SOP and then an `end_of_frame`.
- Write latency: a pixel pushed in cycle t is at the head and poppable in cycle t+1.
- Read latency: 0. Pixel data is valid in the same cycle as `read_enable`; the timing generator registers it.
- Pop when full re-enables `stream_ready` in the next cycle, not combinationally in the same cycle.
- Push and pop in the same cycle when empty: the pop sees empty (underflow). The pushed word is retained.
- `underflow` and `frame_error` are registered: they pulse for exactly 1 cycle, the cycle after the event.
- DROP→ARM takes 1 cycle after the SOP reaches the head.
- Pointers wrap modulo FIFO_DEPTH.

## Test plan
Bench parameters: H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=4, CW=9.
- Reset, then stream 8 pixels (sop on pixel 0, eop on pixel 7, data 1..8). Pulse `end_of_frame`, then give 8 `read_enable` cycles -> colours show 1..8 in order, no error pulses, state returns to DROP.
- Hold the source valid with 6 pixels while there is no `read_enable` -> `stream_ready` drops after 4 accepts. One pop -> `stream_ready`=1 the next cycle, and the 5th pixel is accepted.
- Source stalls after pixel 3 while `read_enable` continues -> `underflow` pulses once, colours are 0, and the remaining pixels 4..8 are discarded in DROP until the next SOP.
- Packet of 5 pixels with eop on pixel 5 -> `frame_error` pulses after the 5th pop. The next frame displays correctly after the following `end_of_frame`.
- Packet of 8 pixels without eop, followed by garbage and then a new SOP -> `frame_error` after the 8th pop, garbage is dropped, and the new SOP is armed.
- Assert `reset` low mid-RUN with 3 pixels buffered -> all outputs take their reset values immediately (asynchronously) and `stream_ready`=1. After release, `read_enable` gives black until the SOP plus `end_of_frame` sequence completes.

Source files
------------

// File: rtl/vga_pixel_stream_buffer_if.sv
// Avalon-ST RGB pixel stream between a pixel source and the VGA pixel buffer.
interface vga_pixel_stream_buffer_if #(
  parameter int CW = 9
);
  logic [3*(CW+1)-1:0] stream_data;
  logic                stream_startofpacket;
  logic                stream_endofpacket;
  logic                stream_valid;
  logic                stream_ready;

  modport master (
    output stream_data, stream_startofpacket, stream_endofpacket, stream_valid,
    input  stream_ready
  );

  modport slave (
    input  stream_data, stream_startofpacket, stream_endofpacket, stream_valid,
    output stream_ready
  );
endinterface

// File: rtl/vga_pixel_stream_buffer.sv
// Small pixel FIFO that aligns each Avalon-ST packet to the display frame using
// end_of_frame, presenting one pixel per read_enable with zero read latency.
module vga_pixel_stream_buffer #(
  parameter int CW         = 9,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  vga_pixel_stream_buffer_if.slave   stream,
  input  logic                       read_enable,
  input  logic                       end_of_frame,
  output logic [CW:0]                red_to_vga_display,
  output logic [CW:0]                green_to_vga_display,
  output logic [CW:0]                blue_to_vga_display,
  output logic                       underflow,
  output logic                       frame_error
);
  localparam int CH_W = CW + 1;
  localparam int DW   = 3 * CH_W;
  localparam int EW   = DW + 2;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [18:0] LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {DROP, ARM, RUN} state_t;

  state_t          state, state_nxt;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [18:0]     pix_cnt, pix_cnt_nxt;
  logic            push, pop, empty, show;
  logic            head_sop, head_eop;
  logic [DW-1:0]   head_data;
  logic            uf_nxt, fe_nxt;
  logic            underflow_p1, frame_error_p1;

  assign empty               = (count == '0);
  assign stream.stream_ready = (count != FULL);
  assign push                = stream.stream_valid & stream.stream_ready;
  assign {head_sop, head_eop, head_data} = mem[rd_ptr];

  // Storage is data-only: validity is carried entirely by count and the pointers.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {stream.stream_startofpacket, stream.stream_endofpacket, stream.stream_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= DROP;
      pix_cnt        <= '0;
      underflow_p1   <= 1'b0;
      frame_error_p1 <= 1'b0;
    end else begin
      state          <= state_nxt;
      pix_cnt        <= pix_cnt_nxt;
      underflow_p1   <= uf_nxt;
      frame_error_p1 <= fe_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pix_cnt_nxt = pix_cnt;
    pop         = 1'b0;
    uf_nxt      = 1'b0;
    fe_nxt      = 1'b0;
    case (state)
      DROP: begin
        if (!empty) begin
          if (head_sop) state_nxt = ARM;
          else          pop       = 1'b1;
        end
      end
      ARM: begin
        if (end_of_frame) begin
          state_nxt   = RUN;
          pix_cnt_nxt = '0;
        end
      end
      RUN: begin
        if (read_enable) begin
          if (empty) begin
            uf_nxt    = 1'b1;
            state_nxt = DROP;
          end else if (head_sop && pix_cnt != '0) begin
            // Early SOP: keep it at the head so the new frame can be armed.
            fe_nxt    = 1'b1;
            state_nxt = ARM;
          end else begin
            pop         = 1'b1;
            pix_cnt_nxt = pix_cnt + 19'd1;
            if (pix_cnt == LAST) begin
              fe_nxt    = ~head_eop;
              state_nxt = DROP;
            end else if (head_eop) begin
              fe_nxt    = 1'b1;
              state_nxt = DROP;
            end
          end
        end
      end
      default: state_nxt = DROP;
    endcase
  end

  assign show = (state == RUN) & read_enable & ~empty;

  assign red_to_vga_display   = show ? head_data[DW-1 -: CH_W]     : '0;
  assign green_to_vga_display = show ? head_data[2*CH_W-1 -: CH_W] : '0;
  assign blue_to_vga_display  = show ? head_data[CH_W-1:0]         : '0;

  assign underflow   = underflow_p1;
  assign frame_error = frame_error_p1;
endmodule

// File: tb/tb_vga_pixel_stream_buffer.sv
// Randomised and directed bench for vga_pixel_stream_buffer with a queue-based frame model.
module tb_vga_pixel_stream_buffer;
  localparam int CW    = 9;
  localparam int H     = 4;
  localparam int V     = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int NPIX  = H * V;
  localparam int M_DROP = 0, M_ARM = 1, M_RUN = 2;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [29:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic read_enable = 1'b0;
  logic end_of_frame = 1'b0;
  logic [CW:0] red, green, blue;
  logic underflow, frame_error;

  vga_pixel_stream_buffer_if #(.CW(CW)) sif ();

  vga_pixel_stream_buffer #(
    .CW(CW), .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(DEPTH), .AW(AW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .stream              (sif),
    .read_enable         (read_enable),
    .end_of_frame        (end_of_frame),
    .red_to_vga_display  (red),
    .green_to_vga_display(green),
    .blue_to_vga_display (blue),
    .underflow           (underflow),
    .frame_error         (frame_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  ent_t src_q[$];
  logic [29:0] last_col;
  logic        last_rdy;
  int n_acc, n_uf, n_fe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is the next H*V pixels starting at an SOP, released by end_of_frame.
  ent_t mq[$];
  int   m_mode = M_DROP;
  int   m_pix  = 0;
  bit   m_uf   = 0;
  bit   m_fe   = 0;

  always @(negedge clk) begin
    bit   pop, push, nuf, nfe;
    ent_t e;
    logic [29:0] exp_col;
    if (!reset) begin
      mq.delete();
      m_mode = M_DROP;
      m_pix  = 0;
      m_uf   = 0;
      m_fe   = 0;
    end else begin
      exp_col = (m_mode == M_RUN && read_enable && mq.size() > 0) ? mq[0].data : 30'd0;
      chk("ready", 32'(sif.stream_ready), 32'(mq.size() != DEPTH));
      chk("colour", 32'({red, green, blue}), 32'(exp_col));
      chk("underflow", 32'(underflow), 32'(m_uf));
      chk("frame_error", 32'(frame_error), 32'(m_fe));
      pop = 0; nuf = 0; nfe = 0;
      case (m_mode)
        M_DROP: if (mq.size() > 0) begin
          if (mq[0].sop) m_mode = M_ARM;
          else pop = 1;
        end
        M_ARM: if (end_of_frame) begin
          m_mode = M_RUN;
          m_pix  = 0;
        end
        default: if (read_enable) begin
          if (mq.size() == 0) begin
            nuf = 1; m_mode = M_DROP;
          end else if (mq[0].sop && m_pix != 0) begin
            nfe = 1; m_mode = M_ARM;
          end else begin
            pop = 1;
            if (m_pix == NPIX - 1) begin
              nfe = !mq[0].eop; m_mode = M_DROP;
            end else if (mq[0].eop) begin
              nfe = 1; m_mode = M_DROP;
            end
            m_pix++;
          end
        end
      endcase
      push   = sif.stream_valid && (mq.size() != DEPTH);
      e.sop  = sif.stream_startofpacket;
      e.eop  = sif.stream_endofpacket;
      e.data = sif.stream_data;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(e);
      m_uf = nuf;
      m_fe = nfe;
    end
  end

  task automatic add_pkt(input int n, input int base, input bit sop_first, input bit eop_last);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e.sop  = sop_first && (i == 0);
      e.eop  = eop_last && (i == n - 1);
      e.data = 30'(base + i);
      src_q.push_back(e);
    end
  endtask

  // Entered and left at posedge+1; inputs are held for the whole cycle.
  task automatic cycle(input bit v_en, input bit re, input bit eof);
    bit acc;
    sif.stream_valid = v_en && (src_q.size() > 0);
    if (src_q.size() > 0) begin
      sif.stream_startofpacket = src_q[0].sop;
      sif.stream_endofpacket   = src_q[0].eop;
      sif.stream_data          = src_q[0].data;
    end else begin
      sif.stream_startofpacket = 1'($urandom_range(0, 1));
      sif.stream_endofpacket   = 1'($urandom_range(0, 1));
      sif.stream_data          = 30'($urandom);
    end
    read_enable  = re;
    end_of_frame = eof;
    @(negedge clk);
    last_col = {red, green, blue};
    last_rdy = sif.stream_ready;
    acc = sif.stream_valid && sif.stream_ready;
    n_acc += int'(acc);
    n_uf  += int'(underflow);
    n_fe  += int'(frame_error);
    @(posedge clk);
    #1;
    if (acc) void'(src_q.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sif.stream_valid = 1'b0;
    read_enable = 1'b0;
    end_of_frame = 1'b0;
    src_q.delete();
    #1;
    chk("rst_ready", 32'(sif.stream_ready), 32'd1);
    chk("rst_colour", 32'({red, green, blue}), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);
    chk("rst_fe", 32'(frame_error), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic show_frame(input int base);
    for (int k = 0; k < NPIX; k++) begin
      cycle(1, 1, 0);
      chk("frame_pix", 32'(last_col), 32'(base + k));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    sif.stream_valid = 1'b0;
    sif.stream_startofpacket = 1'b0;
    sif.stream_endofpacket = 1'b0;
    sif.stream_data = '0;
    @(posedge clk);
    #1;

    // Clean frame: pixels 1..8 in order, no error pulses.
    do_reset();
    add_pkt(8, 1, 1, 1);
    repeat (6) cycle(1, 0, 0);
    cycle(1, 0, 1);
    n_uf = 0; n_fe = 0;
    show_frame(1);
    repeat (2) cycle(1, 0, 0);
    chk("s1_uf", 32'(n_uf), 32'd0);
    chk("s1_fe", 32'(n_fe), 32'd0);

    // Backpressure: 4 accepts then stall; a pop frees a slot one cycle later.
    do_reset();
    add_pkt(8, 16, 1, 1);
    n_acc = 0;
    repeat (6) cycle(1, 0, 0);
    chk("s2_accepts", 32'(n_acc), 32'd4);
    chk("s2_full", 32'(last_rdy), 32'd0);
    cycle(1, 0, 1);
    cycle(1, 1, 0);
    chk("s2_pop_pix", 32'(last_col), 32'd16);
    chk("s2_rdy_same", 32'(last_rdy), 32'd0);
    n_acc = 0;
    cycle(1, 0, 0);
    chk("s2_rdy_next", 32'(last_rdy), 32'd1);
    chk("s2_fifth", 32'(n_acc), 32'd1);

    // Source stall: underflow once, black output, tail of the packet dropped.
    do_reset();
    add_pkt(3, 32, 1, 0);
    repeat (4) cycle(1, 0, 0);
    cycle(1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, 0);
      chk("s3_pix", 32'(last_col), 32'(32 + k));
    end
    n_uf = 0;
    cycle(1, 1, 0);
    chk("s3_blank", 32'(last_col), 32'd0);
    add_pkt(5, 35, 0, 1);
    repeat (8) cycle(1, 0, 0);
    chk("s3_uf_once", 32'(n_uf), 32'd1);
    add_pkt(8, 48, 1, 1);
    repeat (6) cycle(1, 0, 0);
    cycle(1, 0, 1);
    show_frame(48);

    // Short packet: frame_error after the 5th pop, next frame recovers.
    do_reset();
    add_pkt(5, 64, 1, 1);
    add_pkt(8, 80, 1, 1);
    repeat (6) cycle(1, 0, 0);
    cycle(1, 0, 1);
    n_fe = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1, 1, 0);
      chk("s4_pix", 32'(last_col), 32'(64 + k));
    end
    chk("s4_fe_before", 32'(n_fe), 32'd0);
    cycle(1, 0, 0);
    chk("s4_fe_pulse", 32'(n_fe), 32'd1);
    repeat (4) cycle(1, 0, 0);
    cycle(1, 0, 1);
    show_frame(80);
    repeat (2) cycle(1, 0, 0);
    chk("s4_fe_total", 32'(n_fe), 32'd1);

    // Missing EOP, garbage, then a fresh SOP gets armed.
    do_reset();
    add_pkt(8, 96, 1, 0);
    add_pkt(3, 200, 0, 0);
    add_pkt(8, 112, 1, 1);
    repeat (6) cycle(1, 0, 0);
    cycle(1, 0, 1);
    n_fe = 0;
    show_frame(96);
    repeat (8) cycle(1, 0, 0);
    chk("s5_fe", 32'(n_fe), 32'd1);
    cycle(1, 0, 1);
    show_frame(112);

    // Asynchronous reset in the middle of a running frame.
    do_reset();
    add_pkt(8, 128, 1, 1);
    repeat (6) cycle(1, 0, 0);
    cycle(1, 0, 1);
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    chk("s6_pix2", 32'(last_col), 32'd129);
    read_enable = 1'b1;
    #2;
    chk("s6_pre_col", 32'({red, green, blue}), 32'd130);
    reset = 1'b0;
    #1;
    chk("s6_col", 32'({red, green, blue}), 32'd0);
    chk("s6_ready", 32'(sif.stream_ready), 32'd1);
    chk("s6_uf", 32'(underflow), 32'd0);
    chk("s6_fe", 32'(frame_error), 32'd0);
    src_q.delete();
    sif.stream_valid = 1'b0;
    read_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) begin
      cycle(1, 1, 0);
      chk("s6_black", 32'(last_col), 32'd0);
    end
    add_pkt(8, 144, 1, 1);
    repeat (5) begin
      cycle(1, 1, 0);
      chk("s6_wait", 32'(last_col), 32'd0);
    end
    cycle(1, 0, 1);
    show_frame(144);

    // Random traffic, good and malformed packets, checked cycle by cycle by the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (src_q.size() < 4) begin
        if ($urandom_range(0, 3) != 0)
          add_pkt(8, int'($urandom_range(1, 1 << 29)), 1, 1);
        else
          add_pkt(int'($urandom_range(1, 10)), int'($urandom_range(1, 1 << 29)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
